// File: rtl/cpu_fetch_pkg.sv
// Shared constants for the instruction fetch front end.
// Defines the instruction and address widths, the NOP encoding and the default reset PC.
package cpu_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int FETCH_ADDR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc4, instruction} entries.
// Head data is a 0-cycle read. Flush overrides push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;
    assign rdata = mem_r[rd_ptr_r];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && !empty;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents beyond the valid window are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_queue_chk.sv
// Runtime checks for the fetch queue: FIFO overflow and counter bounds.
module instr_fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   full,
    input  logic [$clog2(DEPTH):0] outstanding,
    input  logic [$clog2(DEPTH):0] drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= CW'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n) drop_cnt <= outstanding);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited in-order reads,
// buffers returned words and feeds IF/ID, dropping stale responses after a redirect.
module instr_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] rsp_pc_r;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     drop_cnt_r;
    logic              run_r;

    logic [ADDR_W-1:0] fetch_pc_nxt_s;
    logic [ADDR_W-1:0] rsp_pc_nxt_s;
    logic [CW-1:0]     outstanding_nxt_s;
    logic [CW-1:0]     drop_cnt_nxt_s;

    logic              credit_s;
    logic              accept_s;
    logic              drop_rsp_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [EW-1:0]     fifo_head_s;
    logic [EW-1:0]     fifo_wdata_s;

    // Issue/credit and FIFO handshake decisions.
    always_comb begin
        credit_s       = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CW+1)'(DEPTH);
        imem_req_valid = run_r && !redirect_valid && credit_s;
        accept_s       = imem_req_valid && imem_req_ready;
        drop_rsp_s     = imem_rsp_valid && (drop_cnt_r != CW'(0));
        push_s         = imem_rsp_valid && (drop_cnt_r == CW'(0)) && !redirect_valid;
        pop_s          = !fifo_empty_s && !stall && !redirect_valid;
        fifo_wdata_s   = {rsp_pc_r + ADDR_W'(4), imem_rsp_data};
        imem_req_addr  = fetch_pc_r;
    end

    // rsp_pc tracks the address of the next live response, so pc tags need no per-request storage.
    always_comb begin
        outstanding_nxt_s = outstanding_r + CW'(accept_s) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            drop_cnt_nxt_s = outstanding_r - CW'(imem_rsp_valid);
            fetch_pc_nxt_s = redirect_pc;
            rsp_pc_nxt_s   = redirect_pc;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r - CW'(drop_rsp_s);
            fetch_pc_nxt_s = accept_s ? (fetch_pc_r + ADDR_W'(4)) : fetch_pc_r;
            rsp_pc_nxt_s   = push_s ? (rsp_pc_r + ADDR_W'(4)) : rsp_pc_r;
        end
    end

    // Fetch state registers; run_r keeps requests off until the cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CW'(0);
            drop_cnt_r    <= CW'(0);
            run_r         <= 1'b0;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            rsp_pc_r      <= rsp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            run_r         <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata (fifo_wdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s),
        .rdata (fifo_head_s)
    );

    // IF/ID view of the FIFO head, forced to NOP/0 when nothing is buffered.
    always_comb begin
        if_id_valid = !fifo_empty_s;
        if (if_id_valid) begin
            if_id_instr = fifo_head_s[DATA_W-1:0];
            if_id_pc4   = fifo_head_s[EW-1:DATA_W];
        end else begin
            if_id_instr = DATA_W'(NOP_INSTR);
            if_id_pc4   = ADDR_W'(0);
        end
    end

    instr_fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .pop         (pop_s),
        .full        (fifo_full_s),
        .outstanding (outstanding_r),
        .drop_cnt    (drop_cnt_r)
    );

endmodule
